id_ex_stage: RTL and testbench
==============================

Name: id_ex_stage

Overview:
- ID/EX pipeline stage. Sits directly downstream of the ID-stage control decoder and consumes its EX[3:0], MEM[2:0] and WB[1:0] bundles.
- Registers the control bundles together with the decoded operands: PC+4, both register-file read values, the sign-extended immediate, and rs/rt/rd.
- Contains load-use hazard detection. On a hazard it inserts a bubble into ID/EX and holds the PC and IF/ID registers.
- Keeps a saturating stall counter for performance debug.

Parameters:
- DATA_W, 32, width of the PC, operand and immediate datapaths.
- REG_W, 5, register-specifier width.
- CNT_W, 16, width of the stall counter.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- ex_in  in  4  {regDest, aluOp[1:0], aluSrc} from the control decoder.
- mem_in  in  3  {branch, memRead, memWrite}.
- wb_in  in  2  {regWrite, memToReg}.
- flush_in  in  1  squashes the instruction currently in ID.
- pc4_in  in  DATA_W  PC+4 of the ID instruction.
- rd1_in, rd2_in  in  DATA_W  register-file read data.
- imm_in  in  DATA_W  sign-extended immediate.
- rs_in, rt_in, rd_in  in  REG_W  ID instruction register fields.
- ex_out, mem_out, wb_out  out  4/3/2  registered control bundles.
- pc4_out, rd1_out, rd2_out, imm_out  out  DATA_W  registered data.
- rs_out, rt_out, rd_out  out  REG_W  registered register specifiers.
- valid_out  out  1  1 = real instruction in EX; 0 = bubble or reset.
- pc_write  out  1  combinational; 0 holds the PC.
- if_id_write  out  1  combinational; 0 holds IF/ID.
- stall_count  out  CNT_W  number of hazard stall cycles since reset.

Behaviour:
- Reset (sampled at the rising edge):
  - All registered outputs go to 0: bundles, data, specifiers, valid_out, stall_count.
  - While reset is high, pc_write = if_id_write = 0.
- Hazard, combinational from the registered state and the ID inputs:
  - hazard = mem_out[1] & valid_out & (rt_out != 0) & ((rt_out == rs_in) | (rt_out == rt_in)).
- Bubble = hazard | flush_in. On a bubble edge:
  - ex_out, mem_out, wb_out and valid_out load 0.
  - Data and specifier registers still load their inputs (don't-care, but deterministic).
- Normal edge: every register loads its corresponding input and valid_out loads 1. Latency is exactly 1 cycle from input to output.
- pc_write = if_id_write = ~(hazard & ~flush_in) & ~reset.
- flush_in has priority over hazard:
  - The PC and IF/ID are not held.
  - A bubble is inserted.
  - stall_count does not increment.
- stall_count increments by 1 on each edge where hazard & ~flush_in & ~reset. It saturates at 2^CNT_W-1 and never wraps.
- A load followed by two dependent instructions stalls exactly one cycle:
  - After the bubble, valid_out = 0, so hazard deasserts.
  - Forwarding resolves the remaining dependence; that is outside this block.
- A back-to-back load pair (lw $2; lw $3,0($2)) stalls one cycle. A load into $0 never stalls.
- Reset asserted mid-stall: the next edge clears all state, and pc_write reasserts the cycle after reset deasserts.
- There is no other state machine. The only states are {valid instruction, bubble}, encoded in valid_out.

Decomposition:
- Shared package holds:
  - bundle widths EX_W = 4, MEM_W = 3, WB_W = 2;
  - bit-index constants (MEM_READ = 1, WB_REGWRITE = 1, EX_REGDEST = 3, etc.);
  - the CNT_W default.
- Sub-module hazard_unit is purely combinational:
  - inputs: ID/EX memRead, valid, rt; ID rs, rt; flush_in;
  - outputs: hazard, bubble, pc_write, if_id_write.
- The register bank and the counter remain in id_ex_stage.

Test Plan:
- Reset: drive nonzero inputs with reset = 1 for 2 cycles -> all outputs 0, pc_write = 0, stall_count = 0. Deassert reset -> pc_write = 1.
- R-type pass-through: ex_in = 4'b1100, wb_in = 2'b10, rd1_in = 32'h12345678 -> one cycle later ex_out = 4'b1100, wb_out = 2'b10, rd1_out = 32'h12345678, valid_out = 1.
- Load-use stall:
  - Cycle n: lw with mem_in = 3'b010, rt_in = 5'd2.
  - Cycle n+1: ID presents rs_in = 5'd2 -> pc_write = if_id_write = 0 during n+1.
  - Next edge: ex_out = mem_out = wb_out = 0, valid_out = 0, stall_count = 1.
  - Cycle n+2: pc_write = 1.
- $0 and non-load cases:
  - lw with rt_in = 0 followed by rs_in = 0 -> no stall.
  - sw (mem_in = 3'b001) followed by a dependent instruction -> no stall.
- Flush versus hazard: load-use hazard and flush_in = 1 in the same cycle -> pc_write = 1, bubble inserted, stall_count unchanged.
- Saturation: with CNT_W = 2, force 5 hazard cycles -> stall_count = 3 and stays at 3.

Source files
------------

// File: rtl/id_ex_pkg.sv
// Shared constants and bundle types for the ID/EX stage.
// Bit positions of the decoder bundles live here so users stay in sync.
package id_ex_pkg;

  localparam int EX_W  = 4;
  localparam int MEM_W = 3;
  localparam int WB_W  = 2;

  localparam int EX_ALUSRC   = 0;
  localparam int EX_ALUOP_LO = 1;
  localparam int EX_ALUOP_HI = 2;
  localparam int EX_REGDEST  = 3;

  localparam int MEM_WRITE  = 0;
  localparam int MEM_READ   = 1;
  localparam int MEM_BRANCH = 2;

  localparam int WB_MEMTOREG = 0;
  localparam int WB_REGWRITE = 1;

  localparam int CNT_W_DEF = 16;

  typedef struct packed {
    logic [EX_W-1:0]  ex;
    logic [MEM_W-1:0] mem;
    logic [WB_W-1:0]  wb;
    logic             valid;
  } ctrl_t;

  localparam ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/id_ex_stage_hazard_unit.sv
// Load-use hazard detection between the EX-resident load and the ID operands.
// Purely combinational; flush wins over a hazard so the front end is not held.
module hazard_unit
  import id_ex_pkg::*;
#(
  parameter int REG_W = 5
) (
  input  logic             memread_i,
  input  logic             valid_i,
  input  logic [REG_W-1:0] rt_ex_i,
  input  logic [REG_W-1:0] rs_id_i,
  input  logic [REG_W-1:0] rt_id_i,
  input  logic             flush_i,
  output logic             hazard_o,
  output logic             bubble_o,
  output logic             pc_write_o,
  output logic             if_id_write_o
);

  logic dest_nz;
  logic dep;

  assign dest_nz  = (rt_ex_i != '0);
  assign dep      = (rt_ex_i == rs_id_i) | (rt_ex_i == rt_id_i);
  assign hazard_o = memread_i & valid_i & dest_nz & dep;
  assign bubble_o = hazard_o | flush_i;

  assign pc_write_o    = ~(hazard_o & ~flush_i);
  assign if_id_write_o = ~(hazard_o & ~flush_i);

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion
// and a saturating stall counter for performance debug.
module id_ex_stage
  import id_ex_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [EX_W-1:0]   ex_in,
  input  logic [MEM_W-1:0]  mem_in,
  input  logic [WB_W-1:0]   wb_in,
  input  logic              flush_in,
  input  logic [DATA_W-1:0] pc4_in,
  input  logic [DATA_W-1:0] rd1_in,
  input  logic [DATA_W-1:0] rd2_in,
  input  logic [DATA_W-1:0] imm_in,
  input  logic [REG_W-1:0]  rs_in,
  input  logic [REG_W-1:0]  rt_in,
  input  logic [REG_W-1:0]  rd_in,
  output logic [EX_W-1:0]   ex_out,
  output logic [MEM_W-1:0]  mem_out,
  output logic [WB_W-1:0]   wb_out,
  output logic [DATA_W-1:0] pc4_out,
  output logic [DATA_W-1:0] rd1_out,
  output logic [DATA_W-1:0] rd2_out,
  output logic [DATA_W-1:0] imm_out,
  output logic [REG_W-1:0]  rs_out,
  output logic [REG_W-1:0]  rt_out,
  output logic [REG_W-1:0]  rd_out,
  output logic              valid_out,
  output logic              pc_write,
  output logic              if_id_write,
  output logic [CNT_W-1:0]  stall_count
);

  ctrl_t ctrl_q, ctrl_d;
  logic [DATA_W-1:0] pc4_q, rd1_q, rd2_q, imm_q;
  logic [REG_W-1:0]  rs_q, rt_q, rd_q;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic hazard;
  logic bubble;
  logic hu_pc_write;
  logic hu_if_id_write;
  logic stall;

  hazard_unit #(
    .REG_W (REG_W)
  ) u_hazard (
    .memread_i     (ctrl_q.mem[MEM_READ]),
    .valid_i       (ctrl_q.valid),
    .rt_ex_i       (rt_q),
    .rs_id_i       (rs_in),
    .rt_id_i       (rt_in),
    .flush_i       (flush_in),
    .hazard_o      (hazard),
    .bubble_o      (bubble),
    .pc_write_o    (hu_pc_write),
    .if_id_write_o (hu_if_id_write)
  );

  assign stall = hazard & ~flush_in & ~reset;

  always_comb begin
    ctrl_d.ex    = ex_in;
    ctrl_d.mem   = mem_in;
    ctrl_d.wb    = wb_in;
    ctrl_d.valid = 1'b1;
    if (bubble) ctrl_d = CTRL_BUBBLE;
    cnt_d = cnt_q;
    // Saturate rather than wrap so long runs still read as "many stalls".
    if (stall && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ctrl_q <= CTRL_BUBBLE;
      pc4_q  <= '0;
      rd1_q  <= '0;
      rd2_q  <= '0;
      imm_q  <= '0;
      rs_q   <= '0;
      rt_q   <= '0;
      rd_q   <= '0;
      cnt_q  <= '0;
    end else begin
      ctrl_q <= ctrl_d;
      pc4_q  <= pc4_in;
      rd1_q  <= rd1_in;
      rd2_q  <= rd2_in;
      imm_q  <= imm_in;
      rs_q   <= rs_in;
      rt_q   <= rt_in;
      rd_q   <= rd_in;
      cnt_q  <= cnt_d;
    end
  end

  assign ex_out      = ctrl_q.ex;
  assign mem_out     = ctrl_q.mem;
  assign wb_out      = ctrl_q.wb;
  assign valid_out   = ctrl_q.valid;
  assign pc4_out     = pc4_q;
  assign rd1_out     = rd1_q;
  assign rd2_out     = rd2_q;
  assign imm_out     = imm_q;
  assign rs_out      = rs_q;
  assign rt_out      = rt_q;
  assign rd_out      = rd_q;
  assign stall_count = cnt_q;

  assign pc_write    = hu_pc_write & ~reset;
  assign if_id_write = hu_if_id_write & ~reset;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed vector table, saturation sequence,
// and randomized traffic against an instruction-level reference model.
module tb_id_ex_stage;

  logic        clock;
  logic        reset;
  logic [3:0]  ex_in;
  logic [2:0]  mem_in;
  logic [1:0]  wb_in;
  logic        flush_in;
  logic [31:0] pc4_in, rd1_in, rd2_in, imm_in;
  logic [4:0]  rs_in, rt_in, rd_in;

  logic [3:0]  ex_out;
  logic [2:0]  mem_out;
  logic [1:0]  wb_out;
  logic [31:0] pc4_out, rd1_out, rd2_out, imm_out;
  logic [4:0]  rs_out, rt_out, rd_out;
  logic        valid_out, pc_write, if_id_write;
  logic [15:0] stall_count;

  logic [3:0]  s_ex_out;
  logic [2:0]  s_mem_out;
  logic [1:0]  s_wb_out;
  logic [31:0] s_pc4_out, s_rd1_out, s_rd2_out, s_imm_out;
  logic [4:0]  s_rs_out, s_rt_out, s_rd_out;
  logic        s_valid_out, s_pc_write, s_if_id_write;
  logic [1:0]  s_stall_count;

  int n_cmp = 0;
  int n_bad = 0;

  id_ex_stage dut (
    .clock(clock), .reset(reset),
    .ex_in(ex_in), .mem_in(mem_in), .wb_in(wb_in),
    .flush_in(flush_in), .pc4_in(pc4_in),
    .rd1_in(rd1_in), .rd2_in(rd2_in), .imm_in(imm_in),
    .rs_in(rs_in), .rt_in(rt_in), .rd_in(rd_in),
    .ex_out(ex_out), .mem_out(mem_out), .wb_out(wb_out),
    .pc4_out(pc4_out), .rd1_out(rd1_out), .rd2_out(rd2_out),
    .imm_out(imm_out), .rs_out(rs_out), .rt_out(rt_out),
    .rd_out(rd_out), .valid_out(valid_out),
    .pc_write(pc_write), .if_id_write(if_id_write),
    .stall_count(stall_count)
  );

  id_ex_stage #(.CNT_W(2)) dut_sat (
    .clock(clock), .reset(reset),
    .ex_in(ex_in), .mem_in(mem_in), .wb_in(wb_in),
    .flush_in(flush_in), .pc4_in(pc4_in),
    .rd1_in(rd1_in), .rd2_in(rd2_in), .imm_in(imm_in),
    .rs_in(rs_in), .rt_in(rt_in), .rd_in(rd_in),
    .ex_out(s_ex_out), .mem_out(s_mem_out), .wb_out(s_wb_out),
    .pc4_out(s_pc4_out), .rd1_out(s_rd1_out), .rd2_out(s_rd2_out),
    .imm_out(s_imm_out), .rs_out(s_rs_out), .rt_out(s_rt_out),
    .rd_out(s_rd_out), .valid_out(s_valid_out),
    .pc_write(s_pc_write), .if_id_write(s_if_id_write),
    .stall_count(s_stall_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic [3:0] ex,
                       input logic [2:0] mem, input logic [1:0] wb,
                       input logic fl, input logic [4:0] rs,
                       input logic [4:0] rt, input logic [4:0] rd,
                       input logic [31:0] rd1, input logic [31:0] rd2,
                       input logic [31:0] pc4, input logic [31:0] imm);
    reset = r; ex_in = ex; mem_in = mem; wb_in = wb;
    flush_in = fl; rs_in = rs; rt_in = rt; rd_in = rd;
    rd1_in = rd1; rd2_in = rd2; pc4_in = pc4; imm_in = imm;
  endtask

  typedef struct {
    logic        rst;
    logic [3:0]  ex;
    logic [2:0]  mem;
    logic [1:0]  wb;
    logic        fl;
    logic [4:0]  rs, rt;
    logic [31:0] rd1;
    logic        e_pcw;
    logic [3:0]  e_ex;
    logic [2:0]  e_mem;
    logic [1:0]  e_wb;
    logic        e_val;
    int          e_cnt;
    logic [31:0] e_rd1;
  } vec_t;

  function automatic vec_t mk(
    logic r, logic [3:0] ex, logic [2:0] mem, logic [1:0] wb, logic fl,
    logic [4:0] rs, logic [4:0] rt, logic [31:0] rd1, logic pcw,
    logic [3:0] eex, logic [2:0] emem, logic [1:0] ewb, logic ev,
    int ec, logic [31:0] erd1);
    vec_t v;
    v.rst = r; v.ex = ex; v.mem = mem; v.wb = wb; v.fl = fl;
    v.rs = rs; v.rt = rt; v.rd1 = rd1; v.e_pcw = pcw;
    v.e_ex = eex; v.e_mem = emem; v.e_wb = ewb; v.e_val = ev;
    v.e_cnt = ec; v.e_rd1 = erd1;
    return v;
  endfunction

  vec_t tbl[20];

  // Reference model: what instruction sits in EX, described by its fields.
  int          ld_dest;
  logic [3:0]  m_ex;
  logic [2:0]  m_mem;
  logic [1:0]  m_wb;
  logic        m_val;
  logic [31:0] m_pc4, m_rd1, m_rd2, m_imm;
  logic [4:0]  m_rs, m_rt, m_rd;
  int          m_cnt, m_cnt2;

  initial begin
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    tbl[0]  = mk(1,4'hF,3'h7,2'h3,0,5'd1,5'd2,32'hdeadbeef,0,0,0,0,0,0,0);
    tbl[1]  = mk(1,4'hF,3'h7,2'h3,0,5'd1,5'd2,32'hdeadbeef,0,0,0,0,0,0,0);
    tbl[2]  = mk(0,4'hC,3'h0,2'h2,0,5'd3,5'd4,32'h12345678,1,4'hC,0,2'h2,1,0,32'h12345678);
    tbl[3]  = mk(0,4'h1,3'h2,2'h3,0,5'd5,5'd2,32'h11,1,4'h1,3'h2,2'h3,1,0,32'h11);
    tbl[4]  = mk(0,4'hC,3'h0,2'h2,0,5'd2,5'd6,32'h22,0,0,0,0,0,1,32'h22);
    tbl[5]  = mk(0,4'hC,3'h0,2'h2,0,5'd2,5'd6,32'h22,1,4'hC,0,2'h2,1,1,32'h22);
    tbl[6]  = mk(0,4'h1,3'h2,2'h3,0,5'd7,5'd0,32'h33,1,4'h1,3'h2,2'h3,1,1,32'h33);
    tbl[7]  = mk(0,4'hC,3'h0,2'h2,0,5'd0,5'd0,32'h44,1,4'hC,0,2'h2,1,1,32'h44);
    tbl[8]  = mk(0,4'h1,3'h1,2'h0,0,5'd8,5'd9,32'h55,1,4'h1,3'h1,2'h0,1,1,32'h55);
    tbl[9]  = mk(0,4'hC,3'h0,2'h2,0,5'd9,5'd1,32'h66,1,4'hC,0,2'h2,1,1,32'h66);
    tbl[10] = mk(0,4'h1,3'h2,2'h3,0,5'd2,5'd3,32'h77,1,4'h1,3'h2,2'h3,1,1,32'h77);
    tbl[11] = mk(0,4'h1,3'h2,2'h3,0,5'd3,5'd5,32'h88,0,0,0,0,0,2,32'h88);
    tbl[12] = mk(0,4'h1,3'h2,2'h3,0,5'd3,5'd5,32'h88,1,4'h1,3'h2,2'h3,1,2,32'h88);
    tbl[13] = mk(0,4'hC,3'h0,2'h2,1,5'd5,5'd1,32'h99,1,0,0,0,0,2,32'h99);
    tbl[14] = mk(0,4'hC,3'h0,2'h2,0,5'd5,5'd1,32'h99,1,4'hC,0,2'h2,1,2,32'h99);
    tbl[15] = mk(0,4'h1,3'h2,2'h3,0,5'd1,5'd4,32'haa,1,4'h1,3'h2,2'h3,1,2,32'haa);
    tbl[16] = mk(1,4'hC,3'h0,2'h2,0,5'd4,5'd1,32'hbb,0,0,0,0,0,0,0);
    tbl[17] = mk(0,4'hC,3'h0,2'h2,0,5'd4,5'd1,32'hbb,1,4'hC,0,2'h2,1,0,32'hbb);
    tbl[18] = mk(0,4'h1,3'h2,2'h3,0,5'd1,5'd6,32'hcc,1,4'h1,3'h2,2'h3,1,0,32'hcc);
    tbl[19] = mk(0,4'hC,3'h0,2'h2,0,5'd1,5'd6,32'hdd,0,0,0,0,0,1,32'hdd);

    foreach (tbl[i]) begin
      drive(tbl[i].rst, tbl[i].ex, tbl[i].mem, tbl[i].wb, tbl[i].fl,
            tbl[i].rs, tbl[i].rt, 5'(i), tbl[i].rd1, 32'h5a5a0000 + i,
            32'(i * 4), 32'hffff0000 | i);
      @(negedge clock);
      chk($sformatf("t%0d pc_write", i), 64'(pc_write), 64'(tbl[i].e_pcw));
      chk($sformatf("t%0d if_id_write", i), 64'(if_id_write), 64'(tbl[i].e_pcw));
      @(posedge clock); #1;
      chk($sformatf("t%0d ex_out", i), 64'(ex_out), 64'(tbl[i].e_ex));
      chk($sformatf("t%0d mem_out", i), 64'(mem_out), 64'(tbl[i].e_mem));
      chk($sformatf("t%0d wb_out", i), 64'(wb_out), 64'(tbl[i].e_wb));
      chk($sformatf("t%0d valid_out", i), 64'(valid_out), 64'(tbl[i].e_val));
      chk($sformatf("t%0d stall_count", i), 64'(stall_count), 64'(tbl[i].e_cnt));
      chk($sformatf("t%0d rd1_out", i), 64'(rd1_out), 64'(tbl[i].e_rd1));
    end

    // Saturation: five load-use stalls on a 2-bit counter.
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clock); #1;
    for (int k = 1; k <= 5; k++) begin
      drive(0, 4'h1, 3'h2, 2'h3, 0, 5'd1, 5'd2, 5'd0, 0, 0, 0, 0);
      @(posedge clock); #1;
      drive(0, 4'hC, 3'h0, 2'h2, 0, 5'd2, 5'd7, 5'd3, 0, 0, 0, 0);
      @(negedge clock);
      chk($sformatf("sat%0d pc_write", k), 64'(s_pc_write), 64'(0));
      @(posedge clock); #1;
      @(posedge clock); #1;
      chk($sformatf("sat%0d count2", k), 64'(s_stall_count),
          64'((k > 3) ? 3 : k));
      chk($sformatf("sat%0d count16", k), 64'(stall_count), 64'(k));
    end
    drive(0, 4'h1, 3'h2, 2'h3, 0, 5'd1, 5'd2, 5'd0, 0, 0, 0, 0);
    @(posedge clock); #1;
    drive(0, 4'hC, 3'h0, 2'h2, 0, 5'd2, 5'd2, 5'd3, 0, 0, 0, 0);
    @(posedge clock); #1;
    chk("sat hold count2", 64'(s_stall_count), 64'(3));

    // Randomized traffic against the instruction-level model.
    for (int i = 0; i < 400; i++) begin
      logic        r, fl, dep, bub;
      logic [3:0]  ex;
      logic [2:0]  mem;
      logic [1:0]  wb;
      logic [4:0]  rs, rt, rd;
      logic [31:0] d1, d2, pc4, imm;
      r   = (i == 0) || ($urandom_range(0, 39) == 0);
      fl  = ($urandom_range(0, 7) == 0);
      ex  = 4'($urandom);
      mem = 3'($urandom);
      wb  = 2'($urandom);
      rs  = 5'($urandom_range(0, 3));
      rt  = 5'($urandom_range(0, 3));
      rd  = 5'($urandom);
      d1  = $urandom; d2 = $urandom; pc4 = $urandom; imm = $urandom;
      drive(r, ex, mem, wb, fl, rs, rt, rd, d1, d2, pc4, imm);

      dep = (ld_dest > 0) && (ld_dest == int'(rs) || ld_dest == int'(rt));
      @(negedge clock);
      if (i > 0) begin
        chk("rnd pc_write", 64'(pc_write), 64'(!r && !(dep && !fl)));
        chk("rnd if_id_write", 64'(if_id_write), 64'(!r && !(dep && !fl)));
      end

      if (r) begin
        m_ex = 0; m_mem = 0; m_wb = 0; m_val = 0;
        m_pc4 = 0; m_rd1 = 0; m_rd2 = 0; m_imm = 0;
        m_rs = 0; m_rt = 0; m_rd = 0;
        m_cnt = 0; m_cnt2 = 0; ld_dest = -1;
      end else begin
        bub = dep || fl;
        m_ex  = bub ? 4'h0 : ex;
        m_mem = bub ? 3'h0 : mem;
        m_wb  = bub ? 2'h0 : wb;
        m_val = !bub;
        m_pc4 = pc4; m_rd1 = d1; m_rd2 = d2; m_imm = imm;
        m_rs = rs; m_rt = rt; m_rd = rd;
        if (dep && !fl) begin
          if (m_cnt < 65535) m_cnt++;
          if (m_cnt2 < 3) m_cnt2++;
        end
        ld_dest = (!bub && mem[1]) ? int'(rt) : -1;
      end

      @(posedge clock); #1;
      chk("rnd ex_out", 64'(ex_out), 64'(m_ex));
      chk("rnd mem_out", 64'(mem_out), 64'(m_mem));
      chk("rnd wb_out", 64'(wb_out), 64'(m_wb));
      chk("rnd valid_out", 64'(valid_out), 64'(m_val));
      chk("rnd pc4_out", 64'(pc4_out), 64'(m_pc4));
      chk("rnd rd1_out", 64'(rd1_out), 64'(m_rd1));
      chk("rnd rd2_out", 64'(rd2_out), 64'(m_rd2));
      chk("rnd imm_out", 64'(imm_out), 64'(m_imm));
      chk("rnd rs_out", 64'(rs_out), 64'(m_rs));
      chk("rnd rt_out", 64'(rt_out), 64'(m_rt));
      chk("rnd rd_out", 64'(rd_out), 64'(m_rd));
      chk("rnd stall_count", 64'(stall_count), 64'(m_cnt));
      chk("rnd stall_count2", 64'(s_stall_count), 64'(m_cnt2));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
